ntp_clock_axi_regs: RTL and testbench
=====================================

NTP_CLOCK_AXI_REGS -- requirements
Module: ntp_clock_axi_regs

Interface
REQ-001 Parameters SHALL be: CORE_NAME, 32'h6e747063, constant returned at word 0; CORE_VERSION, 32'h00010000, constant returned at word 1.
REQ-002 axi_aclk  in  1  sole clock; all logic on its rising edge.
REQ-003 axi_aresetn  in  1  reset, asynchronous assert, active-low.
REQ-004 axi_awaddr in 5, axi_awprot in 3, axi_awvalid in 1, axi_awready out 1: AXI4-Lite write-address channel; prot ignored.
REQ-005 axi_wdata in 32, axi_wstrb in 4, axi_wvalid in 1, axi_wready out 1: write-data channel.
REQ-006 axi_bresp out 2, axi_bvalid out 1, axi_bready in 1: write-response channel.
REQ-007 axi_araddr in 5, axi_arprot in 3, axi_arvalid in 1, axi_arready out 1: read-address channel; prot ignored.
REQ-008 axi_rdata out 32, axi_rresp out 2, axi_rvalid out 1, axi_rready in 1: read-data channel.
REQ-009 ntp_time in 64, sync_ok in 1, pll_locked in 1: status from NTP clock core, synchronous to axi_aclk.
REQ-010 ctrl_enable out 1, ctrl_mode out 3, time_offset out 32: control outputs driven directly from registers.

Function
REQ-011 Register map (word = addr[4:2], addr[1:0] ignored) SHALL be: 0 NAME RO; 1 VERSION RO; 2 CTRL RW bits[3:0] (bit0 enable, bits3:1 mode), bits[31:4] read 0; 3 STATUS RO {30'b0, pll_locked, sync_ok}; 4 TIME_HI RO; 5 TIME_LO RO; 6 OFFSET RW 32 bits; 7 SCRATCH RW 32 bits.
REQ-012 AW and W SHALL be accepted independently, in either order or the same cycle; awready = no AW held AND bvalid low; wready = no W held AND bvalid low.
REQ-013 Write SHALL commit on the edge after both AW and W are held; bvalid rises on that same edge; write latency = 1 cycle after the later handshake.
REQ-014 RW registers SHALL update only byte lanes with wstrb bit set; wstrb = 0 gives OKAY, no change.
REQ-015 Writes to RO words (0,1,3,4,5) SHALL have no effect and return bresp = SLVERR (2'b10); RW writes return OKAY (2'b00).
REQ-016 bvalid/bresp SHALL hold stable until bready is high at an edge; no new AW/W is accepted while bvalid is high.
REQ-017 arready SHALL equal NOT rvalid; rdata/rresp registered, rvalid rising one cycle after the AR handshake; held stable until rready.
REQ-018 All reads SHALL return rresp = OKAY.
REQ-019 Reading TIME_HI SHALL return ntp_time[63:32] and, on the same edge, latch ntp_time[31:0] into a shadow; reading TIME_LO returns the shadow (coherent 64-bit read, HI first).
REQ-020 A read and a write to the same register in flight together SHALL be independent; read returns the pre-commit value if its AR handshake precedes the write commit edge.
REQ-021 Simultaneous AR and AW/W handshakes in one cycle SHALL all be accepted.

Reset
REQ-022 On axi_aresetn low: awready, wready, arready, bvalid, rvalid = 0; bresp, rresp, rdata = 0; CTRL, OFFSET, SCRATCH, TIME_LO shadow = 0; held AW/W cleared.
REQ-023 Ready outputs SHALL rise on the first edge after reset release; a transaction in flight at reset is discarded with no response.

Structure
REQ-024 Register word indices, bresp/rresp codes and reset values SHALL live in a shared package (ntp_axi_regs_pkg).
REQ-025 Single module, no sub-modules; address decode shared by read and write paths.

Verification
REQ-026 AW at cycle 0, W at cycle 3 to word 7, data 32'hDEADBEEF, strb 4'hF -> bvalid at cycle 4, OKAY; read word 7 -> 32'hDEADBEEF.
REQ-027 Write word 6 data 32'h11223344 strb 4'b0101 over prior 0 -> read returns 32'h00220044, ctrl outputs unchanged.
REQ-028 ntp_time = 64'h0000_0001_8000_0000, read TIME_HI, change ntp_time to 64'h0000_0002_0000_0000, read TIME_LO -> 32'h00000001 then 32'h80000000.
REQ-029 Write word 1 -> bresp 2'b10; read word 1 -> 32'h00010000; read word 0 -> 32'h6e747063.
REQ-030 bready held low 10 cycles after write -> bvalid/bresp stable, awready/wready low throughout; rready low 10 cycles -> rdata stable, arready low.
REQ-031 Assert axi_aresetn low with AW held and rvalid high -> all valid/ready 0 immediately, CTRL reads 0 after release, ctrl_enable = 0.

Source files
------------

// File: rtl/ntp_axi_regs_pkg.sv
// Shared definitions for the NTP clock AXI4-Lite register block:
// word indices, response codes, reset values and small decode helpers.
package ntp_axi_regs_pkg;

    typedef enum logic [2:0] {
        W_NAME    = 3'd0,
        W_VERSION = 3'd1,
        W_CTRL    = 3'd2,
        W_STATUS  = 3'd3,
        W_TIME_HI = 3'd4,
        W_TIME_LO = 3'd5,
        W_OFFSET  = 3'd6,
        W_SCRATCH = 3'd7
    } reg_word_e;

    localparam logic [1:0]  RESP_OKAY     = 2'b00;
    localparam logic [1:0]  RESP_SLVERR   = 2'b10;

    localparam logic [3:0]  CTRL_RESET    = '0;
    localparam logic [31:0] OFFSET_RESET  = '0;
    localparam logic [31:0] SCRATCH_RESET = '0;
    localparam logic [31:0] SHADOW_RESET  = '0;

    // Word index from byte address bits [4:2]; used by both read and write paths.
    function automatic reg_word_e decode_word(input logic [2:0] word_bits);
        return reg_word_e'(word_bits);
    endfunction

    function automatic logic is_rw_word(input reg_word_e w);
        return (w == W_CTRL) || (w == W_OFFSET) || (w == W_SCRATCH);
    endfunction

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int unsigned i = 0; i < 4; i++) begin
            if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/ntp_clock_axi_regs.sv
// AXI4-Lite register block for the NTP clock core: identification,
// control, status, coherent 64-bit time readout, offset and scratch.
import ntp_axi_regs_pkg::*;

module ntp_clock_axi_regs #(
    parameter logic [31:0] CORE_NAME    = 32'h6e747063,
    parameter logic [31:0] CORE_VERSION = 32'h00010000
) (
    input  logic        axi_aclk,
    input  logic        axi_aresetn,
    input  logic [4:0]  axi_awaddr,
    input  logic [2:0]  axi_awprot,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    output logic [1:0]  axi_bresp,
    output logic        axi_bvalid,
    input  logic        axi_bready,
    input  logic [4:0]  axi_araddr,
    input  logic [2:0]  axi_arprot,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    output logic        axi_rvalid,
    input  logic        axi_rready,
    input  logic [63:0] ntp_time,
    input  logic        sync_ok,
    input  logic        pll_locked,
    output logic        ctrl_enable,
    output logic [2:0]  ctrl_mode,
    output logic [31:0] time_offset
);

    // Protection bits and byte offset within a word carry no meaning here.
    logic [7:0] unused_bits;
    assign unused_bits = {axi_awprot, axi_arprot, axi_awaddr[1:0], axi_araddr[1:0]};

    logic        ready_en;
    logic        aw_held;
    reg_word_e   aw_word;
    logic        w_held;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        bvalid_q;
    logic [1:0]  bresp_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic [3:0]  ctrl_q;
    logic [31:0] offset_q;
    logic [31:0] scratch_q;
    logic [31:0] time_lo_shadow;

    logic        aw_hs, w_hs, ar_hs, commit;
    reg_word_e   rd_word;
    logic [31:0] rd_value;
    logic [31:0] wr_base;
    logic [31:0] wr_merged;

    // ready_en keeps every ready low until the first edge after reset release.
    assign axi_awready = ready_en & ~aw_held & ~bvalid_q;
    assign axi_wready  = ready_en & ~w_held  & ~bvalid_q;
    assign axi_arready = ready_en & ~rvalid_q;

    assign aw_hs  = axi_awvalid & axi_awready;
    assign w_hs   = axi_wvalid  & axi_wready;
    assign ar_hs  = axi_arvalid & axi_arready;
    assign commit = aw_held & w_held;

    assign axi_bvalid = bvalid_q;
    assign axi_bresp  = bresp_q;
    assign axi_rvalid = rvalid_q;
    assign axi_rdata  = rdata_q;
    assign axi_rresp  = rresp_q;

    assign ctrl_enable = ctrl_q[0];
    assign ctrl_mode   = ctrl_q[3:1];
    assign time_offset = offset_q;

    assign rd_word = decode_word(axi_araddr[4:2]);

    // Read data mux for the word addressed by the read channel.
    always_comb begin
        rd_value = '0;
        unique case (rd_word)
            W_NAME:    rd_value = CORE_NAME;
            W_VERSION: rd_value = CORE_VERSION;
            W_CTRL:    rd_value = {28'b0, ctrl_q};
            W_STATUS:  rd_value = {30'b0, pll_locked, sync_ok};
            W_TIME_HI: rd_value = ntp_time[63:32];
            W_TIME_LO: rd_value = time_lo_shadow;
            W_OFFSET:  rd_value = offset_q;
            W_SCRATCH: rd_value = scratch_q;
        endcase
    end

    // Current value of the held write target merged with the held data under strobe.
    always_comb begin
        wr_base = '0;
        unique case (aw_word)
            W_CTRL:    wr_base = {28'b0, ctrl_q};
            W_OFFSET:  wr_base = offset_q;
            W_SCRATCH: wr_base = scratch_q;
            default:   wr_base = '0;
        endcase
        wr_merged = merge_bytes(wr_base, w_data, w_strb);
    end

    // Write channel: capture AW and W independently, commit once both are held.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            ready_en <= 1'b0;
            aw_held  <= 1'b0;
            aw_word  <= W_NAME;
            w_held   <= 1'b0;
            w_data   <= '0;
            w_strb   <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            ready_en <= 1'b1;
            if (bvalid_q && axi_bready) bvalid_q <= 1'b0;
            if (commit) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                bvalid_q <= 1'b1;
                bresp_q  <= is_rw_word(aw_word) ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (aw_hs) begin
                    aw_held <= 1'b1;
                    aw_word <= decode_word(axi_awaddr[4:2]);
                end
                if (w_hs) begin
                    w_held <= 1'b1;
                    w_data <= axi_wdata;
                    w_strb <= axi_wstrb;
                end
            end
        end
    end

    // RW register storage, updated on the commit edge.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            ctrl_q    <= CTRL_RESET;
            offset_q  <= OFFSET_RESET;
            scratch_q <= SCRATCH_RESET;
        end else if (commit) begin
            unique case (aw_word)
                W_CTRL:    ctrl_q    <= wr_merged[3:0];
                W_OFFSET:  offset_q  <= wr_merged;
                W_SCRATCH: scratch_q <= wr_merged;
                default:   ;
            endcase
        end
    end

    // Read channel: registered response, TIME_HI read snapshots the low half.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            rvalid_q       <= 1'b0;
            rdata_q        <= '0;
            rresp_q        <= RESP_OKAY;
            time_lo_shadow <= SHADOW_RESET;
        end else begin
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_value;
                rresp_q  <= RESP_OKAY;
                if (rd_word == W_TIME_HI) time_lo_shadow <= ntp_time[31:0];
            end else if (rvalid_q && axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ntp_clock_axi_regs.sv
// Directed self-checking bench for ntp_clock_axi_regs.
module tb_ntp_clock_axi_regs;

    logic        axi_aclk = 1'b0;
    logic        axi_aresetn;
    logic [4:0]  axi_awaddr;
    logic [2:0]  axi_awprot;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;
    logic [4:0]  axi_araddr;
    logic [2:0]  axi_arprot;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready;
    logic [63:0] ntp_time;
    logic        sync_ok;
    logic        pll_locked;
    logic        ctrl_enable;
    logic [2:0]  ctrl_mode;
    logic [31:0] time_offset;

    int checks   = 0;
    int failures = 0;

    always #5 axi_aclk = ~axi_aclk;

    ntp_clock_axi_regs #(
        .CORE_NAME    (32'h6e747063),
        .CORE_VERSION (32'h00010000)
    ) dut (
        .axi_aclk    (axi_aclk),
        .axi_aresetn (axi_aresetn),
        .axi_awaddr  (axi_awaddr),
        .axi_awprot  (axi_awprot),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_wdata   (axi_wdata),
        .axi_wstrb   (axi_wstrb),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_bresp   (axi_bresp),
        .axi_bvalid  (axi_bvalid),
        .axi_bready  (axi_bready),
        .axi_araddr  (axi_araddr),
        .axi_arprot  (axi_arprot),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_rdata   (axi_rdata),
        .axi_rresp   (axi_rresp),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready),
        .ntp_time    (ntp_time),
        .sync_ok     (sync_ok),
        .pll_locked  (pll_locked),
        .ctrl_enable (ctrl_enable),
        .ctrl_mode   (ctrl_mode),
        .time_offset (time_offset)
    );

    // Full write transaction; inputs change and outputs are sampled on the falling edge.
    task automatic do_write(input logic [4:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
        bit aw_done, w_done, a, w;
        int n;
        axi_awaddr = addr; axi_wdata = data; axi_wstrb = strb;
        axi_awvalid = 1'b1; axi_wvalid = 1'b1;
        aw_done = 0; w_done = 0; n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            a = axi_awready && axi_awvalid;
            w = axi_wready && axi_wvalid;
            @(posedge axi_aclk); @(negedge axi_aclk); n++;
            if (a) begin aw_done = 1; axi_awvalid = 1'b0; end
            if (w) begin w_done = 1; axi_wvalid = 1'b0; end
        end
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        resp = 2'bxx;
        if (!(aw_done && w_done)) begin
            checks++; failures++;
            $display("FAIL write_handshake_timeout addr=%h", addr);
            return;
        end
        n = 0;
        while (!axi_bvalid && n < 20) begin @(negedge axi_aclk); n++; end
        if (!axi_bvalid) begin
            checks++; failures++;
            $display("FAIL bvalid_timeout addr=%h", addr);
            return;
        end
        resp = axi_bresp;
        axi_bready = 1'b1;
        @(posedge axi_aclk); @(negedge axi_aclk);
        axi_bready = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
        bit done, a;
        int n;
        axi_araddr = addr; axi_arvalid = 1'b1;
        done = 0; n = 0;
        while (!done && n < 20) begin
            a = axi_arready;
            @(posedge axi_aclk); @(negedge axi_aclk); n++;
            if (a) done = 1;
        end
        axi_arvalid = 1'b0;
        data = 'x; resp = 2'bxx;
        if (!done) begin
            checks++; failures++;
            $display("FAIL read_handshake_timeout addr=%h", addr);
            return;
        end
        n = 0;
        while (!axi_rvalid && n < 20) begin @(negedge axi_aclk); n++; end
        if (!axi_rvalid) begin
            checks++; failures++;
            $display("FAIL rvalid_timeout addr=%h", addr);
            return;
        end
        data = axi_rdata; resp = axi_rresp;
        axi_rready = 1'b1;
        @(posedge axi_aclk); @(negedge axi_aclk);
        axi_rready = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] got;
        got = {axi_awready, axi_wready, axi_arready, axi_bvalid, axi_rvalid, ctrl_enable, 1'b0};
        checks++;
        if (got !== 7'b0) begin failures++; $display("FAIL reset_handshake got=%b want=%b", got, 7'b0); end
        checks++;
        if ({axi_rdata, axi_bresp, axi_rresp, time_offset} !== 68'h0) begin
            failures++; $display("FAIL reset_data rdata=%h bresp=%b rresp=%b offset=%h",
                                 axi_rdata, axi_bresp, axi_rresp, time_offset);
        end
        @(negedge axi_aclk); axi_aresetn = 1'b1;
        #1;
        checks++;
        if ({axi_awready, axi_arready} !== 2'b00) begin
            failures++; $display("FAIL ready_before_edge got=%b want=00", {axi_awready, axi_arready});
        end
        @(posedge axi_aclk); @(negedge axi_aclk);
        checks++;
        if ({axi_awready, axi_wready, axi_arready} !== 3'b111) begin
            failures++; $display("FAIL ready_after_release got=%b want=111",
                                 {axi_awready, axi_wready, axi_arready});
        end
    endtask

    // AW at cycle 0, W at cycle 3, bvalid one edge after the W handshake.
    task automatic test_write_latency();
        logic [31:0] d; logic [1:0] r;
        axi_awaddr = 5'h1C; axi_awvalid = 1'b1;
        @(posedge axi_aclk); @(negedge axi_aclk);
        axi_awvalid = 1'b0;
        checks++;
        if (axi_awready !== 1'b0) begin failures++; $display("FAIL awready_while_held got=%b want=0", axi_awready); end
        @(posedge axi_aclk); @(negedge axi_aclk);
        @(posedge axi_aclk); @(negedge axi_aclk);
        axi_wdata = 32'hDEADBEEF; axi_wstrb = 4'hF; axi_wvalid = 1'b1;
        checks++;
        if (axi_wready !== 1'b1) begin failures++; $display("FAIL wready_cycle3 got=%b want=1", axi_wready); end
        @(posedge axi_aclk); @(negedge axi_aclk);
        axi_wvalid = 1'b0;
        checks++;
        if (axi_bvalid !== 1'b0) begin failures++; $display("FAIL bvalid_early got=%b want=0", axi_bvalid); end
        @(posedge axi_aclk); @(negedge axi_aclk);
        checks++;
        if ({axi_bvalid, axi_bresp} !== 3'b100) begin
            failures++; $display("FAIL bvalid_cycle4 got=%b want=100", {axi_bvalid, axi_bresp});
        end
        axi_bready = 1'b1;
        @(posedge axi_aclk); @(negedge axi_aclk);
        axi_bready = 1'b0;
        checks++;
        if (axi_bvalid !== 1'b0) begin failures++; $display("FAIL bvalid_clear got=%b want=0", axi_bvalid); end
        do_read(5'h1C, d, r);
        checks++;
        if ({d, r} !== {32'hDEADBEEF, 2'b00}) begin
            failures++; $display("FAIL scratch_read got=%h/%b want=deadbeef/00", d, r);
        end
    endtask

    // W presented before AW.
    task automatic test_write_order();
        logic [31:0] d; logic [1:0] r;
        axi_wdata = 32'h12345678; axi_wstrb = 4'hF; axi_wvalid = 1'b1;
        @(posedge axi_aclk); @(negedge axi_aclk);
        axi_wvalid = 1'b0;
        @(posedge axi_aclk); @(negedge axi_aclk);
        axi_awaddr = 5'h1F; axi_awvalid = 1'b1;
        @(posedge axi_aclk); @(negedge axi_aclk);
        axi_awvalid = 1'b0;
        @(posedge axi_aclk); @(negedge axi_aclk);
        checks++;
        if ({axi_bvalid, axi_bresp} !== 3'b100) begin
            failures++; $display("FAIL w_first_bresp got=%b want=100", {axi_bvalid, axi_bresp});
        end
        axi_bready = 1'b1;
        @(posedge axi_aclk); @(negedge axi_aclk);
        axi_bready = 1'b0;
        do_read(5'h1C, d, r);
        checks++;
        if (d !== 32'h12345678) begin failures++; $display("FAIL w_first_read got=%h want=12345678", d); end
    endtask

    task automatic test_strobe();
        logic [31:0] d; logic [1:0] r;
        do_write(5'h18, 32'h11223344, 4'b0101, r);
        checks++;
        if (r !== 2'b00) begin failures++; $display("FAIL offset_bresp got=%b want=00", r); end
        do_read(5'h18, d, r);
        checks++;
        if (d !== 32'h00220044) begin failures++; $display("FAIL offset_strobe got=%h want=00220044", d); end
        checks++;
        if ({time_offset, ctrl_enable, ctrl_mode} !== {32'h00220044, 1'b0, 3'b000}) begin
            failures++; $display("FAIL offset_outputs offset=%h en=%b mode=%b want=00220044/0/000",
                                 time_offset, ctrl_enable, ctrl_mode);
        end
        do_write(5'h18, 32'hFFFFFFFF, 4'b0000, r);
        do_read(5'h18, d, r);
        checks++;
        if (d !== 32'h00220044) begin failures++; $display("FAIL offset_strb0 got=%h want=00220044", d); end
    endtask

    task automatic test_ctrl();
        logic [31:0] d; logic [1:0] r;
        do_write(5'h08, 32'hFFFFFFFF, 4'b0001, r);
        do_read(5'h08, d, r);
        checks++;
        if (d !== 32'h0000000F) begin failures++; $display("FAIL ctrl_read got=%h want=0000000f", d); end
        checks++;
        if ({ctrl_enable, ctrl_mode} !== 4'b1111) begin
            failures++; $display("FAIL ctrl_outputs got=%b want=1111", {ctrl_enable, ctrl_mode});
        end
        do_write(5'h08, 32'h00000000, 4'b1110, r);
        do_read(5'h08, d, r);
        checks++;
        if (d !== 32'h0000000F) begin failures++; $display("FAIL ctrl_upper_lanes got=%h want=0000000f", d); end
        do_write(5'h08, 32'h0000000A, 4'b0001, r);
        checks++;
        if ({ctrl_enable, ctrl_mode} !== 4'b0101) begin
            failures++; $display("FAIL ctrl_mode5 got=%b want=0101", {ctrl_enable, ctrl_mode});
        end
    endtask

    task automatic test_time_status();
        logic [31:0] d; logic [1:0] r;
        ntp_time = 64'h0000_0001_8000_0000;
        do_read(5'h10, d, r);
        checks++;
        if (d !== 32'h00000001) begin failures++; $display("FAIL time_hi got=%h want=00000001", d); end
        ntp_time = 64'h0000_0002_0000_0000;
        do_read(5'h14, d, r);
        checks++;
        if (d !== 32'h80000000) begin failures++; $display("FAIL time_lo_shadow got=%h want=80000000", d); end
        pll_locked = 1'b1; sync_ok = 1'b0;
        do_read(5'h0C, d, r);
        checks++;
        if (d !== 32'h00000002) begin failures++; $display("FAIL status_pll got=%h want=00000002", d); end
        sync_ok = 1'b1;
        do_read(5'h0D, d, r);
        checks++;
        if (d !== 32'h00000003) begin failures++; $display("FAIL status_both got=%h want=00000003", d); end
    endtask

    task automatic test_ro();
        logic [31:0] d; logic [1:0] r;
        do_write(5'h04, 32'hFFFFFFFF, 4'hF, r);
        checks++;
        if (r !== 2'b10) begin failures++; $display("FAIL ro_version_bresp got=%b want=10", r); end
        do_write(5'h0C, 32'hFFFFFFFF, 4'hF, r);
        checks++;
        if (r !== 2'b10) begin failures++; $display("FAIL ro_status_bresp got=%b want=10", r); end
        do_read(5'h04, d, r);
        checks++;
        if ({d, r} !== {32'h00010000, 2'b00}) begin
            failures++; $display("FAIL version_read got=%h/%b want=00010000/00", d, r);
        end
        do_read(5'h00, d, r);
        checks++;
        if (d !== 32'h6e747063) begin failures++; $display("FAIL name_read got=%h want=6e747063", d); end
    endtask

    task automatic test_backpressure();
        int n;
        int bad;
        axi_awaddr = 5'h1C; axi_wdata = 32'hCAFEF00D; axi_wstrb = 4'hF;
        axi_awvalid = 1'b1; axi_wvalid = 1'b1;
        @(posedge axi_aclk); @(negedge axi_aclk);
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        n = 0;
        while (!axi_bvalid && n < 5) begin @(negedge axi_aclk); n++; end
        axi_awvalid = 1'b1; axi_wvalid = 1'b1;
        axi_wdata = 32'h55555555;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if ({axi_bvalid, axi_bresp, axi_awready, axi_wready} !== 5'b10000) bad++;
            @(posedge axi_aclk); @(negedge axi_aclk);
        end
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL b_backpressure bad_cycles=%0d want=0", bad); end
        axi_bready = 1'b1;
        @(posedge axi_aclk); @(negedge axi_aclk);
        axi_bready = 1'b0;
        axi_araddr = 5'h1C; axi_arvalid = 1'b1;
        @(posedge axi_aclk); @(negedge axi_aclk);
        axi_araddr = 5'h00;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if ({axi_rvalid, axi_rdata, axi_arready} !== {1'b1, 32'hCAFEF00D, 1'b0}) bad++;
            @(posedge axi_aclk); @(negedge axi_aclk);
        end
        axi_arvalid = 1'b0;
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL r_backpressure bad_cycles=%0d want=0", bad); end
        axi_rready = 1'b1;
        @(posedge axi_aclk); @(negedge axi_aclk);
        axi_rready = 1'b0;
    endtask

    // AR, AW and W in one cycle on the same word; read sees the pre-commit value.
    task automatic test_simultaneous();
        logic [31:0] d; logic [1:0] r;
        axi_awaddr = 5'h1C; axi_araddr = 5'h1C;
        axi_wdata = 32'h0BADC0DE; axi_wstrb = 4'hF;
        axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_arvalid = 1'b1;
        checks++;
        if ({axi_awready, axi_wready, axi_arready} !== 3'b111) begin
            failures++; $display("FAIL simul_ready got=%b want=111", {axi_awready, axi_wready, axi_arready});
        end
        @(posedge axi_aclk); @(negedge axi_aclk);
        axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_arvalid = 1'b0;
        checks++;
        if ({axi_rvalid, axi_rdata} !== {1'b1, 32'hCAFEF00D}) begin
            failures++; $display("FAIL simul_old_read got=%b/%h want=1/cafef00d", axi_rvalid, axi_rdata);
        end
        axi_rready = 1'b1;
        @(posedge axi_aclk); @(negedge axi_aclk);
        axi_rready = 1'b0;
        checks++;
        if ({axi_bvalid, axi_bresp} !== 3'b100) begin
            failures++; $display("FAIL simul_bresp got=%b want=100", {axi_bvalid, axi_bresp});
        end
        axi_bready = 1'b1;
        @(posedge axi_aclk); @(negedge axi_aclk);
        axi_bready = 1'b0;
        do_read(5'h1C, d, r);
        checks++;
        if (d !== 32'h0BADC0DE) begin failures++; $display("FAIL simul_new_read got=%h want=0badc0de", d); end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] d; logic [1:0] r;
        int bad;
        do_write(5'h08, 32'h00000003, 4'h1, r);
        checks++;
        if (ctrl_enable !== 1'b1) begin failures++; $display("FAIL ctrl_before_reset got=%b want=1", ctrl_enable); end
        axi_awaddr = 5'h08; axi_awvalid = 1'b1;
        axi_araddr = 5'h1C; axi_arvalid = 1'b1;
        @(posedge axi_aclk); @(negedge axi_aclk);
        axi_awvalid = 1'b0; axi_arvalid = 1'b0;
        checks++;
        if ({axi_rvalid, axi_awready} !== 2'b10) begin
            failures++; $display("FAIL inflight_setup got=%b want=10", {axi_rvalid, axi_awready});
        end
        #2 axi_aresetn = 1'b0;
        #1;
        checks++;
        if ({axi_awready, axi_wready, axi_arready, axi_bvalid, axi_rvalid, ctrl_enable} !== 6'b0) begin
            failures++; $display("FAIL async_reset got=%b want=000000",
                {axi_awready, axi_wready, axi_arready, axi_bvalid, axi_rvalid, ctrl_enable});
        end
        @(negedge axi_aclk); @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        @(posedge axi_aclk); @(negedge axi_aclk);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (axi_bvalid !== 1'b0) bad++;
            @(negedge axi_aclk);
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL discarded_aw bad_cycles=%0d want=0", bad); end
        do_read(5'h08, d, r);
        checks++;
        if ({d, ctrl_enable} !== {32'h0, 1'b0}) begin
            failures++; $display("FAIL ctrl_after_reset got=%h/%b want=00000000/0", d, ctrl_enable);
        end
    endtask

    initial begin
        axi_aresetn = 1'b0;
        axi_awaddr = '0; axi_awprot = '0; axi_awvalid = 1'b0;
        axi_wdata = '0; axi_wstrb = '0; axi_wvalid = 1'b0; axi_bready = 1'b0;
        axi_araddr = '0; axi_arprot = '0; axi_arvalid = 1'b0; axi_rready = 1'b0;
        ntp_time = '0; sync_ok = 1'b0; pll_locked = 1'b0;
        repeat (3) @(negedge axi_aclk);
        test_reset();
        test_write_latency();
        test_write_order();
        test_strobe();
        test_ctrl();
        test_time_status();
        test_ro();
        test_backpressure();
        test_simultaneous();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
